// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, the default operand widths and a
// helper that sizes the iteration counter for a given dividend width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DW_DEF = 6;
    localparam int VW_DEF = 3;

    // The counter must be able to hold the value DW, so it needs
    // enough bits for DW+1 distinct values.
    function automatic int cntWidth(input int dw);
        return $clog2(dw + 1);
    endfunction

    localparam int CNT_W = cntWidth(DW_DEF);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   remIn       - partial remainder before this step (VW+1 bits, guard bit on top)
//   dividendBit - next dividend bit, MSB first
//   divisor     - captured divisor
//   remOut      - partial remainder after the trial subtract / restore
//   quoBit      - quotient bit resolved by this step
module div_step #(
    parameter int VW = 3
) (
    input  logic [VW:0]   remIn,
    input  logic          dividendBit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   remOut,
    output logic          quoBit
);

    logic [VW+1:0] shifted;

    // Shift in the next dividend bit, then trial-subtract. The compare is
    // done on the full shifted value so a set guard bit can never be lost;
    // when the subtraction would go negative the shifted value is kept,
    // which is the "restore" half of the algorithm.
    always_comb begin
        shifted = {remIn, dividendBit};
        quoBit  = (shifted >= {2'b00, divisor});
        if (quoBit) begin
            remOut = shifted[VW:0] - {1'b0, divisor};
        end else begin
            remOut = shifted[VW:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a
// start/done handshake. Intended as the inverse of the 3x3 multiplier.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   start        - request, only honoured while the FSM is idle
//   dividend     - DW-bit unsigned dividend, captured on accept
//   divisor      - VW-bit unsigned divisor, captured on accept
//   busy         - high from accept until the done pulse ends
//   done         - one-cycle pulse, result outputs valid
//   quotient     - DW-bit quotient, held until the next result
//   remainder    - VW-bit remainder, held until the next result
//   div_by_zero  - set with the result when the divisor was zero
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = cntWidth(DW);

    state_t        state_q;
    logic [VW:0]   partRem_q;
    logic [DW-1:0] quoShift_q;
    logic [VW-1:0] divisor_q;
    logic [CW-1:0] count_q;
    logic          divZero_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          divByZero_q;

    logic [VW:0]   partRem_d;
    logic          quoBit_d;

    // quoShift_q doubles as the dividend and quotient shift register:
    // dividend bits leave from the MSB while quotient bits enter at the LSB.
    div_step #(
        .VW(VW)
    ) u_step (
        .remIn      (partRem_q),
        .dividendBit(quoShift_q[DW-1]),
        .divisor    (divisor_q),
        .remOut     (partRem_d),
        .quoBit     (quoBit_d)
    );

    // Control FSM plus datapath registers. The result is registered on the
    // DONE edge, so done rises one edge after the last RUN iteration and the
    // FSM is already back in IDLE during the done cycle, ready to accept a
    // held start on the edge where done falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            partRem_q   <= '0;
            quoShift_q  <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            divZero_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        quoShift_q <= dividend;
                        divisor_q  <= divisor;
                        partRem_q  <= '0;
                        count_q    <= '0;
                        divZero_q  <= (divisor == '0);
                        // A zero divisor skips the iterations entirely.
                        state_q    <= (divisor == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    partRem_q  <= partRem_d;
                    quoShift_q <= {quoShift_q[DW-2:0], quoBit_d};
                    count_q    <= count_q + 1'b1;
                    if (count_q == CW'(DW - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q      <= 1'b1;
                    quotient_q  <= divZero_q ? '1 : quoShift_q;
                    remainder_q <= divZero_q ? '0 : partRem_q[VW-1:0];
                    divByZero_q <= divZero_q;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a table of directed divisions,
// the full multiplier-inverse sweep, and hand-written sequences for
// reset abort, start-while-busy and back-to-back operation.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       divByZero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] dvd;
        logic [2:0] dvs;
        logic [5:0] q;
        logic [2:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    seq_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(divByZero)
    );

    // Single comparison point; every check in the bench passes through here
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issue one start pulse and return the number of edges after the
    // accepting edge at which done was seen (-1 if it never came)
    task automatic applyStimulus(input logic [5:0] dvd, input logic [2:0] dvs, output int lat);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int t1;
        int t2;
        logic sawDone;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{6'd63, 3'd7, 6'd9,  3'd0, 1'b0, 7};
        vecs[1] = '{6'd63, 3'd1, 6'd63, 3'd0, 1'b0, 7};
        vecs[2] = '{6'd5,  3'd7, 6'd0,  3'd5, 1'b0, 7};
        vecs[3] = '{6'd0,  3'd3, 6'd0,  3'd0, 1'b0, 7};
        vecs[4] = '{6'd17, 3'd0, 6'd63, 3'd0, 1'b1, 1};
        vecs[5] = '{6'd17, 3'd5, 6'd3,  3'd2, 1'b0, 7};
        vecs[6] = '{6'd45, 3'd4, 6'd11, 3'd1, 1'b0, 7};
        vecs[7] = '{6'd30, 3'd4, 6'd7,  3'd2, 1'b0, 7};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_quotient", 32'(quotient), 0);
        checkOutput("reset_remainder", 32'(remainder), 0);
        checkOutput("reset_dbz", 32'(divByZero), 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed table, including divide-by-zero followed by a normal op
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            checkOutput($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
            checkOutput($sformatf("vec%0d_dbz", i), 32'(divByZero), 32'(vecs[i].z));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
            checkOutput($sformatf("vec%0d_busy_fall", i), 32'(busy), 0);
        end

        // Multiplier inverse: A*B / B must give A with zero remainder
        for (int a = 0; a < 8; a++) begin
            for (int b = 1; b < 8; b++) begin
                applyStimulus(6'(a * b), 3'(b), lat);
                checkOutput($sformatf("inv_%0dx%0d_quotient", a, b), 32'(quotient), 32'(a));
                checkOutput($sformatf("inv_%0dx%0d_remainder", a, b), 32'(remainder), 0);
                checkOutput($sformatf("inv_%0dx%0d_dbz", a, b), 32'(divByZero), 0);
            end
        end

        // Reset three cycles into a 45/4 run aborts with no done
        @(negedge clk);
        dividend = 6'd45;
        divisor  = 3'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_quotient", 32'(quotient), 0);
        checkOutput("abort_remainder", 32'(remainder), 0);
        checkOutput("abort_dbz", 32'(divByZero), 0);
        sawDone = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) sawDone = 1'b1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 0);
        applyStimulus(6'd45, 3'd4, lat);
        checkOutput("after_abort_latency", 32'(lat), 7);
        checkOutput("after_abort_quotient", 32'(quotient), 11);
        checkOutput("after_abort_remainder", 32'(remainder), 1);

        // Start re-asserted while busy, with operands changed after capture
        @(negedge clk);
        dividend = 6'd50;
        divisor  = 3'd6;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 6'd9;
        divisor  = 3'd3;
        checkOutput("busy_after_accept", 32'(busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 4; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput("busy_start_latency", 32'(lat), 7);
        checkOutput("busy_start_quotient", 32'(quotient), 8);
        checkOutput("busy_start_remainder", 32'(remainder), 2);
        repeat (2) @(posedge clk);

        // Back-to-back with start held high: done pulses 8 cycles apart
        @(negedge clk);
        dividend = 6'd30;
        divisor  = 3'd4;
        start    = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = i;
                end else begin
                    t2 = i;
                    break;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b_spacing", 32'(t2 - t1), 8);
        checkOutput("b2b_quotient", 32'(quotient), 7);
        checkOutput("b2b_remainder", 32'(remainder), 2);
        @(posedge clk);
        #1;
        checkOutput("b2b_busy_fall", 32'(busy), 0);
        checkOutput("b2b_done_fall", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
